two_power_mod_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one two_power_mod engine (2^power mod modulus) between NUM_REQ requesters.
- Sits between the RSA precompute clients (Montgomery R / R^2 constant generation) and the single engine instance.
- Captures one request at a time, issues it to the engine, captures the result and returns it to the owning requester over a valid/ready handshake.
- Serves power==0 locally (result 1) without using the engine.

---
 rtl/two_power_mod_arbiter_if.sv | 49 ++++
 rtl/two_power_mod_arbiter.sv | 142 ++++++++++++++
 tb/tb_two_power_mod_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/two_power_mod_arbiter_if.sv
// Bundles for the arbiter: the requester-facing request/response bus and the
// engine-facing issue/result bus, each with master and slave views.
interface two_power_mod_arbiter_if #(
    parameter int NUM_REQ     = 2,
    parameter int MOD_WIDTH   = 256,
    parameter int POWER_WIDTH = 32
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*MOD_WIDTH-1:0]   req_modulus;
    logic [NUM_REQ*POWER_WIDTH-1:0] req_power;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [NUM_REQ-1:0]             rsp_ready;
    logic [MOD_WIDTH-1:0]           rsp_out;
    logic                           busy;

    // Requesters are the master side; the arbiter is the slave.
    modport master (
        output req_valid, req_modulus, req_power, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, busy
    );
    modport slave (
        input  req_valid, req_modulus, req_power, rsp_ready,
        output req_ready, rsp_valid, rsp_out, busy
    );
endinterface

interface two_power_mod_engine_if #(
    parameter int MOD_WIDTH   = 256,
    parameter int POWER_WIDTH = 32
);
    logic                   eng_i_valid;
    logic                   eng_i_ready;
    logic [MOD_WIDTH-1:0]   eng_i_modulus;
    logic [POWER_WIDTH-1:0] eng_i_power;
    logic                   eng_o_valid;
    logic                   eng_o_ready;
    logic [MOD_WIDTH-1:0]   eng_o_out;

    // The arbiter drives the engine, so it takes the master view.
    modport master (
        output eng_i_valid, eng_i_modulus, eng_i_power, eng_o_ready,
        input  eng_i_ready, eng_o_valid, eng_o_out
    );
    modport slave (
        input  eng_i_valid, eng_i_modulus, eng_i_power, eng_o_ready,
        output eng_i_ready, eng_o_valid, eng_o_out
    );
endinterface

// File: rtl/two_power_mod_arbiter.sv
// Round-robin front end sharing one 2^power mod modulus engine between
// NUM_REQ requesters, one transaction in flight; power==0 is answered locally.
module two_power_mod_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int MOD_WIDTH   = 256,
    parameter int POWER_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    two_power_mod_arbiter_if.slave  io_req,
    two_power_mod_engine_if.master  io_eng
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [IDW-1:0]         r_lastGrant;
    logic [IDW-1:0]         r_curId;
    logic [MOD_WIDTH-1:0]   r_curModulus;
    logic [POWER_WIDTH-1:0] r_curPower;
    logic [MOD_WIDTH-1:0]   r_result;

    logic [IDW-1:0]         w_grant;
    logic                   w_anyValid;
    logic                   w_accept;
    logic [MOD_WIDTH-1:0]   w_selModulus;
    logic [POWER_WIDTH-1:0] w_selPower;

    // Search starts one past the last served requester and wraps, so the
    // previous winner always has the lowest priority.
    function automatic logic [IDW-1:0] rrPick(
        input logic [NUM_REQ-1:0] valid,
        input logic [IDW-1:0]     last
    );
        logic [IDW-1:0] idx;
        logic [IDW-1:0] pick;
        logic           found;
        idx   = last;
        pick  = '0;
        found = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (idx == IDW'(NUM_REQ - 1)) begin
                idx = '0;
            end else begin
                idx = idx + IDW'(1);
            end
            if (!found && valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return pick;
    endfunction

    always_comb begin
        w_anyValid   = |io_req.req_valid;
        w_grant      = rrPick(io_req.req_valid, r_lastGrant);
        w_selModulus = io_req.req_modulus[int'(w_grant) * MOD_WIDTH +: MOD_WIDTH];
        w_selPower   = io_req.req_power[int'(w_grant) * POWER_WIDTH +: POWER_WIDTH];
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_anyValid) begin
                    w_accept    = 1'b1;
                    w_nextState = (w_selPower == '0) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (io_eng.eng_i_ready) begin
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (io_eng.eng_o_valid) begin
                    w_nextState = ST_RESP;
                end
            end
            ST_RESP: begin
                if (io_req.rsp_ready[r_curId]) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Request fields are captured only at accept; the requester may change
    // them freely afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lastGrant  <= IDW'(NUM_REQ - 1);
            r_curId      <= '0;
            r_curModulus <= '0;
            r_curPower   <= '0;
            r_result     <= '0;
        end else begin
            if (w_accept) begin
                r_curId      <= w_grant;
                r_curModulus <= w_selModulus;
                r_curPower   <= w_selPower;
                if (w_selPower == '0) begin
                    r_result <= MOD_WIDTH'(1);
                end
            end
            if (r_state == ST_WAIT && io_eng.eng_o_valid) begin
                r_result <= io_eng.eng_o_out;
            end
            if (r_state == ST_RESP && io_req.rsp_ready[r_curId]) begin
                r_lastGrant <= r_curId;
            end
        end
    end

    assign io_req.req_ready    = (w_accept && !rst) ? (ONE_HOT0 << w_grant) : '0;
    assign io_req.rsp_valid    = (r_state == ST_RESP) ? (ONE_HOT0 << r_curId) : '0;
    assign io_req.rsp_out      = r_result;
    assign io_req.busy         = (r_state != ST_IDLE);
    assign io_eng.eng_i_valid   = (r_state == ST_ISSUE);
    assign io_eng.eng_i_modulus = r_curModulus;
    assign io_eng.eng_i_power   = r_curPower;
    assign io_eng.eng_o_ready   = (r_state == ST_WAIT);
endmodule

// File: tb/tb_two_power_mod_arbiter.sv
// Scoreboard bench for two_power_mod_arbiter with a behavioural engine model
// and directed requester traffic.
module tb_two_power_mod_arbiter;
    localparam int NUM_REQ     = 2;
    localparam int MOD_WIDTH   = 256;
    localparam int POWER_WIDTH = 32;
    localparam int ENG_LAT     = 4;
    localparam int TIMEOUT     = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    two_power_mod_arbiter_if #(
        .NUM_REQ(NUM_REQ), .MOD_WIDTH(MOD_WIDTH), .POWER_WIDTH(POWER_WIDTH)
    ) reqBus ();
    two_power_mod_engine_if #(
        .MOD_WIDTH(MOD_WIDTH), .POWER_WIDTH(POWER_WIDTH)
    ) engBus ();

    two_power_mod_arbiter #(
        .NUM_REQ(NUM_REQ), .MOD_WIDTH(MOD_WIDTH), .POWER_WIDTH(POWER_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io_req(reqBus),
        .io_eng(engBus)
    );

    typedef struct {
        int                     id;
        logic [MOD_WIDTH-1:0]   value;
        logic [POWER_WIDTH-1:0] power;
    } exp_t;

    exp_t rspExp[$];
    exp_t engExp[$];
    int   grantLog[$];

    int checks = 0;
    int errors = 0;
    int pending[2];

    logic                   reqValid0 = 1'b0, reqValid1 = 1'b0;
    logic                   rspReady0 = 1'b1, rspReady1 = 1'b1;
    logic [MOD_WIDTH-1:0]   reqMod0 = '0, reqMod1 = '0;
    logic [POWER_WIDTH-1:0] reqPow0 = '0, reqPow1 = '0;

    assign reqBus.req_valid   = {reqValid1, reqValid0};
    assign reqBus.rsp_ready   = {rspReady1, rspReady0};
    assign reqBus.req_modulus = {reqMod1, reqMod0};
    assign reqBus.req_power   = {reqPow1, reqPow0};

    // Engine model: accepts when idle, answers ENG_LAT edges later.
    logic                 engStall = 1'b0, engBusy = 1'b0, engOValid = 1'b0;
    logic [MOD_WIDTH-1:0] engResult = '0, engOut = '0;
    int                   engCnt = 0;

    assign engBus.eng_i_ready = !engStall && !engBusy && !engOValid;
    assign engBus.eng_o_valid = engOValid;
    assign engBus.eng_o_out   = engOut;

    function automatic logic [MOD_WIDTH-1:0] twoPowMod(
        input logic [MOD_WIDTH-1:0] m, input logic [POWER_WIDTH-1:0] p);
        logic [MOD_WIDTH:0] r;
        logic [MOD_WIDTH:0] mm;
        mm = {1'b0, m};
        r  = (MOD_WIDTH+1)'(1) % mm;
        for (int i = 0; i < int'(p); i++) r = (r << 1) % mm;
        return r[MOD_WIDTH-1:0];
    endfunction

    initial begin : engineModel
        logic hsIn, hsOut;
        forever begin
            @(negedge clk);
            hsIn  = engBus.eng_i_valid && engBus.eng_i_ready;
            hsOut = engBus.eng_o_valid && engBus.eng_o_ready;
            if (hsIn) engResult = twoPowMod(engBus.eng_i_modulus, engBus.eng_i_power);
            @(posedge clk);
            #1;
            if (rst) begin
                engBusy = 1'b0; engOValid = 1'b0; engCnt = 0;
            end else begin
                if (hsOut) engOValid = 1'b0;
                if (hsIn) begin
                    engBusy = 1'b1; engCnt = ENG_LAT;
                end else if (engBusy) begin
                    engCnt--;
                    if (engCnt == 0) begin
                        engBusy = 1'b0; engOValid = 1'b1; engOut = engResult;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [MOD_WIDTH-1:0] actual,
                               input logic [MOD_WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic void popRsp(input int id, output bit found, output exp_t e);
        found = 1'b0;
        e     = '{0, '0, '0};
        for (int i = 0; i < rspExp.size(); i++) begin
            if (!found && rspExp[i].id == id) begin
                found = 1'b1; e = rspExp[i]; rspExp.delete(i);
            end
        end
    endfunction

    function automatic void popEng(input int id, output bit found, output exp_t e);
        found = 1'b0;
        e     = '{0, '0, '0};
        for (int i = 0; i < engExp.size(); i++) begin
            if (!found && engExp[i].id == id) begin
                found = 1'b1; e = engExp[i]; engExp.delete(i);
            end
        end
    endfunction

    // Requester drivers: keep valid high while transactions remain queued.
    task automatic driveRequester(input int id);
        bit acc;
        forever begin
            @(negedge clk);
            acc = reqBus.req_valid[id] && reqBus.req_ready[id];
            @(posedge clk);
            #1;
            if (acc) pending[id]--;
            if (id == 0) reqValid0 = (pending[0] > 0);
            else         reqValid1 = (pending[1] > 0);
        end
    endtask

    initial driveRequester(0);
    initial driveRequester(1);

    // Monitor: pops the scoreboard on every engine and response handshake.
    int   cycle = 0, curGrant = 0, acceptCycle = 0, lastLatency = -1, engHsCount = 0;
    bit   readyDuringBusy = 1'b0, engValidSeen = 1'b0, prevRspAny = 1'b0;

    initial begin : monitor
        bit   found;
        exp_t e;
        forever begin
            @(negedge clk);
            cycle++;
            if (rst) begin
                prevRspAny = 1'b0;
                continue;
            end
            if (reqBus.busy && reqBus.req_ready != '0) readyDuringBusy = 1'b1;
            if (engBus.eng_i_valid) engValidSeen = 1'b1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (reqBus.req_valid[k] && reqBus.req_ready[k]) begin
                    curGrant = k; grantLog.push_back(k); acceptCycle = cycle;
                end
            end
            if (engBus.eng_i_valid && engBus.eng_i_ready) begin
                engHsCount++;
                popEng(curGrant, found, e);
                checkOutput("engIssueExpected", MOD_WIDTH'(found), 1);
                if (found) begin
                    checkOutput("engModulus", engBus.eng_i_modulus, e.value);
                    checkOutput("engPower", MOD_WIDTH'(engBus.eng_i_power), MOD_WIDTH'(e.power));
                end
            end
            if (reqBus.rsp_valid != '0 && !prevRspAny) lastLatency = cycle - acceptCycle;
            prevRspAny = |reqBus.rsp_valid;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (reqBus.rsp_valid[k] && reqBus.rsp_ready[k]) begin
                    checkOutput("rspOneHot", MOD_WIDTH'($countones(reqBus.rsp_valid)), 1);
                    popRsp(k, found, e);
                    checkOutput("rspExpected", MOD_WIDTH'(found), 1);
                    if (found) checkOutput("rspOut", reqBus.rsp_out, e.value);
                end
            end
        end
    end

    task automatic applyStimulus(input int id, input logic [MOD_WIDTH-1:0] modv,
                                 input logic [POWER_WIDTH-1:0] powv,
                                 input logic [MOD_WIDTH-1:0] expVal,
                                 input int count, input bit expectRsp);
        if (id == 0) begin reqMod0 = modv; reqPow0 = powv; end
        else         begin reqMod1 = modv; reqPow1 = powv; end
        for (int i = 0; i < count; i++) begin
            if (expectRsp) rspExp.push_back('{id, expVal, powv});
            if (powv != '0) engExp.push_back('{id, modv, powv});
        end
        pending[id] += count;
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while ((pending[0] != 0 || pending[1] != 0 || rspExp.size() != 0 || reqBus.busy)
               && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "Done"}, MOD_WIDTH'(n < TIMEOUT), 1);
    endtask

    function automatic logic sigVal(input int which);
        case (which)
            0:       return engBus.eng_i_valid;
            1:       return reqBus.rsp_valid[0];
            default: return engBus.eng_o_ready;
        endcase
    endfunction

    task automatic waitSig(input int which, input string name);
        int n = 0;
        while (!sigVal(which) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "Seen"}, MOD_WIDTH'(n < TIMEOUT), 1);
    endtask

    task automatic resetDut();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic int grantOrder();
        int v = 0;
        foreach (grantLog[i]) v = v * 10 + grantLog[i] + 1;
        return v;
    endfunction

    task automatic checkAllClear(input string name);
        checkOutput({name, "Busy"}, MOD_WIDTH'(reqBus.busy), 0);
        checkOutput({name, "RspValid"}, MOD_WIDTH'(reqBus.rsp_valid), 0);
        checkOutput({name, "EngIValid"}, MOD_WIDTH'(engBus.eng_i_valid), 0);
        checkOutput({name, "EngOReady"}, MOD_WIDTH'(engBus.eng_o_ready), 0);
        checkOutput({name, "RspOut"}, reqBus.rsp_out, 0);
        checkOutput({name, "ReqReady"}, MOD_WIDTH'(reqBus.req_ready), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int hsBefore;
        pending[0] = 0;
        pending[1] = 0;

        // Reset state, with requester 0 already asking.
        @(posedge clk);
        #3 applyStimulus(0, 1000, 10, 24, 1, 1);
        repeat (2) @(negedge clk);
        checkAllClear("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Single request.
        hsBefore = engHsCount;
        waitDone("single");
        checkOutput("singleEngHs", MOD_WIDTH'(engHsCount - hsBefore), 1);
        checkOutput("singleLatency", MOD_WIDTH'(lastLatency), 7);

        // Simultaneous requests from reset: requester 0 first.
        resetDut();
        grantLog.delete();
        readyDuringBusy = 1'b0;
        @(posedge clk);
        #3;
        applyStimulus(0, 5, 3, 3, 1, 1);
        applyStimulus(1, 1000, 10, 24, 1, 1);
        waitDone("simul");
        checkOutput("simulOrder", MOD_WIDTH'(grantOrder()), 12);
        checkOutput("simulReadyBusy", MOD_WIDTH'(readyDuringBusy), 0);

        // Round-robin over four transactions.
        grantLog.delete();
        @(posedge clk);
        #3;
        applyStimulus(0, 5, 3, 3, 2, 1);
        applyStimulus(1, 1000, 10, 24, 2, 1);
        waitDone("rr");
        checkOutput("rrOrder", MOD_WIDTH'(grantOrder()), 1212);
        checkOutput("rrReadyBusy", MOD_WIDTH'(readyDuringBusy), 0);

        // Local bypass for power 0.
        engValidSeen = 1'b0;
        hsBefore = engHsCount;
        @(posedge clk);
        #3 applyStimulus(1, 1000, 0, 1, 1, 1);
        waitDone("bypass");
        checkOutput("bypassLatency", MOD_WIDTH'(lastLatency), 1);
        checkOutput("bypassEngValid", MOD_WIDTH'(engValidSeen), 0);
        checkOutput("bypassEngHs", MOD_WIDTH'(engHsCount - hsBefore), 0);

        // Engine and response backpressure.
        @(posedge clk);
        #1;
        engStall  = 1'b1;
        rspReady0 = 1'b0;
        #2 applyStimulus(0, 1000, 10, 24, 1, 1);
        waitSig(0, "stallIssue");
        repeat (5) begin
            checkOutput("stallValid", MOD_WIDTH'(engBus.eng_i_valid), 1);
            checkOutput("stallModulus", engBus.eng_i_modulus, 1000);
            checkOutput("stallPower", MOD_WIDTH'(engBus.eng_i_power), 10);
            @(negedge clk);
        end
        @(posedge clk);
        #1 engStall = 1'b0;
        waitSig(1, "holdRsp");
        repeat (4) begin
            checkOutput("holdRspValid", MOD_WIDTH'(reqBus.rsp_valid), 1);
            checkOutput("holdRspOut", reqBus.rsp_out, 24);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rspReady0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("holdIdleBusy", MOD_WIDTH'(reqBus.busy), 0);
        checkOutput("holdDrained", MOD_WIDTH'(rspExp.size()), 0);

        // Reset while the engine is computing.
        @(posedge clk);
        #3 applyStimulus(0, 1000, 10, 24, 1, 0);
        waitSig(2, "midWait");
        @(posedge clk);
        #1 rst = 1'b1;
        #1 checkAllClear("midReset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("postResetRspValid", MOD_WIDTH'(reqBus.rsp_valid), 0);
        @(posedge clk);
        #3 applyStimulus(0, 1000, 10, 24, 1, 1);
        waitDone("afterReset");
        checkOutput("engExpDrained", MOD_WIDTH'(engExp.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
